// File: rtl/stack_pkg.sv
// Shared types and constants for the hardware stack arbiter.
package stack_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_OP,
    BURST_PUSH,
    BURST_POP,
    DONE
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int unsigned STACK_DEPTH = 1024;
  localparam int unsigned STACK_DW    = 32;

endpackage

// File: rtl/stack_arb_pri.sv
// Two-way CPU/ISR priority picker; ISR wins ties unless it was served last.
module stack_arb_pri (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpu_req,
  input  logic isr_req,
  output logic gnt_cpu,
  output logic gnt_isr
);

  logic last_isr_q;

  always_comb begin
    gnt_isr = en & isr_req & (~cpu_req | ~last_isr_q);
    gnt_cpu = en & cpu_req & ~gnt_isr;
  end

  // Rejected grants also count as served, so a faulty requester cannot starve the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_isr_q <= 1'b0;
    end else if (gnt_cpu | gnt_isr) begin
      last_isr_q <= gnt_isr;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares the hardware stack between CPU single-word ops and ISR save/restore bursts.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH    = STACK_DEPTH,
  parameter int unsigned DW       = STACK_DW,
  parameter int unsigned CW       = $clog2(DEPTH) + 1,
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned LW       = $clog2(MAXBURST) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_op,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_err,
  input  logic          isr_req,
  input  logic          isr_op,
  input  logic [LW-1:0] isr_len,
  output logic          isr_gnt,
  output logic          isr_err,
  output logic          isr_wr_rdy,
  input  logic [DW-1:0] isr_wdata,
  output logic          isr_rvalid,
  output logic [DW-1:0] isr_rdata,
  output logic          isr_done,
  output logic          stk_push,
  output logic          stk_pop,
  output logic [DW-1:0] stk_wdata,
  input  logic [DW-1:0] stk_rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  state_t        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic          cpu_gnt_q, cpu_gnt_d, cpu_err_q, cpu_err_d, cpu_done_q, cpu_done_d;
  logic          isr_gnt_q, isr_gnt_d, isr_err_q, isr_err_d, isr_done_q, isr_done_d;
  logic          isr_rvalid_q, isr_rvalid_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d, isr_rdata_q, isr_rdata_d;
  logic          arb_en, gnt_cpu, gnt_isr, cpu_ok, isr_ok, len_ok;
  logic [CW:0]   push_sum;

  // No arbitration while a grant pulse is out: the winner may still hold its request.
  assign arb_en = (state_q == IDLE) & ~cpu_gnt_q & ~isr_gnt_q;

  stack_arb_pri u_pri (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (arb_en),
    .cpu_req (cpu_req),
    .isr_req (isr_req),
    .gnt_cpu (gnt_cpu),
    .gnt_isr (gnt_isr)
  );

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    push_sum = (CW + 1)'(count_q) + (CW + 1)'(isr_len);
    len_ok   = (isr_len != '0) && (isr_len <= LW'(MAXBURST));
    cpu_ok   = (cpu_op == OP_POP) ? ~empty : ~full;
    isr_ok   = len_ok && ((isr_op == OP_POP) ? (count_q >= CW'(isr_len))
                                             : (push_sum <= (CW + 1)'(DEPTH)));
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    count_d      = count_q + CW'(push_q) - CW'(pop_q);
    push_d       = 1'b0;
    pop_d        = 1'b0;
    cpu_gnt_d    = 1'b0;
    cpu_err_d    = 1'b0;
    cpu_done_d   = 1'b0;
    isr_gnt_d    = 1'b0;
    isr_err_d    = 1'b0;
    isr_done_d   = 1'b0;
    isr_rvalid_d = (state_q == BURST_POP) & pop_q;
    cpu_rdata_d  = ((state_q == CPU_OP) & pop_q) ? stk_rdata : cpu_rdata_q;
    isr_rdata_d  = isr_rvalid_d ? stk_rdata : isr_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_cpu) begin
          cpu_gnt_d = 1'b1;
          if (cpu_ok) begin
            push_d  = (cpu_op == OP_PUSH);
            pop_d   = (cpu_op == OP_POP);
            state_d = CPU_OP;
          end else begin
            cpu_err_d = 1'b1;
          end
        end else if (gnt_isr) begin
          isr_gnt_d = 1'b1;
          if (isr_ok) begin
            rem_d   = isr_len;
            push_d  = (isr_op == OP_PUSH);
            pop_d   = (isr_op == OP_POP);
            state_d = (isr_op == OP_POP) ? BURST_POP : BURST_PUSH;
          end else begin
            isr_err_d = 1'b1;
          end
        end
      end
      CPU_OP: begin
        cpu_done_d = 1'b1;
        state_d    = DONE;
      end
      BURST_PUSH, BURST_POP: begin
        if (rem_q == LW'(1)) begin
          isr_done_d = 1'b1;
          state_d    = DONE;
        end else begin
          rem_d  = rem_q - LW'(1);
          push_d = (state_q == BURST_PUSH);
          pop_d  = (state_q == BURST_POP);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      count_q      <= '0;
      push_q       <= 1'b0;
      pop_q        <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      isr_gnt_q    <= 1'b0;
      isr_err_q    <= 1'b0;
      isr_done_q   <= 1'b0;
      isr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      isr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      count_q      <= count_d;
      push_q       <= push_d;
      pop_q        <= pop_d;
      cpu_gnt_q    <= cpu_gnt_d;
      cpu_err_q    <= cpu_err_d;
      cpu_done_q   <= cpu_done_d;
      isr_gnt_q    <= isr_gnt_d;
      isr_err_q    <= isr_err_d;
      isr_done_q   <= isr_done_d;
      isr_rvalid_q <= isr_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      isr_rdata_q  <= isr_rdata_d;
    end
  end

  always_comb begin
    stk_push   = push_q;
    stk_pop    = pop_q;
    // Write data is taken live in the strobe cycle, so it is gated to zero otherwise.
    stk_wdata  = push_q ? ((state_q == BURST_PUSH) ? isr_wdata : cpu_wdata) : '0;
    isr_wr_rdy = push_q & (state_q == BURST_PUSH);
    cpu_gnt    = cpu_gnt_q;
    cpu_err    = cpu_err_q;
    cpu_done   = cpu_done_q;
    cpu_rdata  = cpu_rdata_q;
    isr_gnt    = isr_gnt_q;
    isr_err    = isr_err_q;
    isr_done   = isr_done_q;
    isr_rvalid = isr_rvalid_q;
    isr_rdata  = isr_rdata_q;
    count      = count_q;
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a negedge-updating behavioural stack.
module tb_stack_arbiter;

  logic        clk, rst_n;
  logic        cpu_req, cpu_op, cpu_gnt, cpu_done, cpu_err;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        isr_req, isr_op, isr_gnt, isr_err, isr_wr_rdy, isr_rvalid, isr_done;
  logic [4:0]  isr_len;
  logic [31:0] isr_wdata, isr_rdata;
  logic        stk_push, stk_pop;
  logic [31:0] stk_wdata, stk_rdata;
  logic [10:0] count;
  logic        full, empty;

  stack_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_op     (cpu_op),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_done   (cpu_done),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .isr_req    (isr_req),
    .isr_op     (isr_op),
    .isr_len    (isr_len),
    .isr_gnt    (isr_gnt),
    .isr_err    (isr_err),
    .isr_wr_rdy (isr_wr_rdy),
    .isr_wdata  (isr_wdata),
    .isr_rvalid (isr_rvalid),
    .isr_rdata  (isr_rdata),
    .isr_done   (isr_done),
    .stk_push   (stk_push),
    .stk_pop    (stk_pop),
    .stk_wdata  (stk_wdata),
    .stk_rdata  (stk_rdata),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: updates on the negedge of a strobe cycle.
  logic [31:0] mem [0:1023];
  int          sp;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp = 0;
      stk_rdata = '0;
    end else begin
      if (stk_push && sp < 1024) begin
        mem[sp] = stk_wdata;
        sp++;
      end
      if (stk_pop && sp > 0) begin
        sp--;
        stk_rdata = mem[sp];
      end
    end
  end

  int n_push, n_pop, n_idone, n_overlap;
  initial begin
    n_push = 0; n_pop = 0; n_idone = 0; n_overlap = 0;
  end
  always @(negedge clk) begin
    if (stk_push) n_push++;
    if (stk_pop) n_pop++;
    if (isr_done) n_idone++;
    if (stk_push && stk_pop) n_overlap++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU op; lat is cycles from grant to cpu_done.
  task automatic cpu_do(input logic op, input logic [31:0] wd, output logic err,
                        output logic [31:0] rd, output int lat);
    logic got;
    got = 1'b0; err = 1'b1; rd = '0; lat = 0;
    cpu_op = op; cpu_wdata = wd; cpu_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cpu_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      cpu_req = 1'b0;
      check("cpu_gnt_timeout", 32'd0, 32'd1);
      return;
    end
    cpu_req = 1'b0;
    err = cpu_err;
    if (err) return;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (cpu_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("cpu_done_timeout", 32'd0, 32'd1);
    rd = cpu_rdata;
  endtask

  logic [31:0] rdq[$];

  task automatic isr_do(input logic op, input logic [4:0] len, input logic [31:0] base,
                        output logic err);
    logic got;
    int   wcnt;
    got = 1'b0; err = 1'b1; wcnt = 0;
    rdq.delete();
    isr_op = op; isr_len = len; isr_wdata = base; isr_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (isr_gnt) begin
        got = 1'b1;
        break;
      end
    end
    isr_req = 1'b0;
    if (!got) begin
      check("isr_gnt_timeout", 32'd0, 32'd1);
      return;
    end
    err = isr_err;
    if (err) return;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      isr_wdata = base + wcnt;
      if (isr_wr_rdy) wcnt++;
      if (isr_rvalid) rdq.push_back(isr_rdata);
      if (isr_done) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) check("isr_done_timeout", 32'd0, 32'd1);
  endtask

  logic        e;
  logic [31:0] r;
  int          lat, p0, d0;
  logic [2:0]  order;
  int          n_gnt, done_cyc, cgnt_cyc;
  logic        reraised;

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_op = 0; cpu_wdata = 0;
    isr_req = 0; isr_op = 0; isr_len = 0; isr_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_strobes", {30'd0, stk_push, stk_pop}, 32'd0);
    #3 rst_n = 1'b1;

    // 1: CPU push then pop
    cpu_do(1'b0, 32'hDEADBEEF, e, r, lat);
    check("t1_push_err", 32'(e), 32'd0);
    check("t1_count1", 32'(count), 32'd1);
    cpu_do(1'b1, 32'd0, e, r, lat);
    check("t1_pop_err", 32'(e), 32'd0);
    check("t1_rdata", r, 32'hDEADBEEF);
    check("t1_latency", 32'(lat), 32'd1);
    check("t1_count0", 32'(count), 32'd0);

    // 2: ISR push burst A..D then pop burst
    p0 = n_push; d0 = n_idone;
    isr_do(1'b0, 5'd4, 32'hA0, e);
    tick();
    check("t2_push_err", 32'(e), 32'd0);
    check("t2_count4", 32'(count), 32'd4);
    check("t2_npush", 32'(n_push - p0), 32'd4);
    check("t2_done_push", 32'(n_idone - d0), 32'd1);
    d0 = n_idone;
    isr_do(1'b1, 5'd4, 32'd0, e);
    tick();
    check("t2_pop_err", 32'(e), 32'd0);
    check("t2_nwords", 32'(rdq.size()), 32'd4);
    if (rdq.size() == 4) begin
      check("t2_w0", rdq[0], 32'hA3);
      check("t2_w1", rdq[1], 32'hA2);
      check("t2_w2", rdq[2], 32'hA1);
      check("t2_w3", rdq[3], 32'hA0);
    end
    check("t2_done_pop", 32'(n_idone - d0), 32'd1);
    check("t2_count0", 32'(count), 32'd0);

    // 3: fill to DEPTH, then overflow push
    for (int i = 0; i < 1024; i++) cpu_do(1'b0, 32'(i), e, r, lat);
    check("t3_count_full", 32'(count), 32'd1024);
    check("t3_full", 32'(full), 32'd1);
    p0 = n_push;
    cpu_do(1'b0, 32'h55, e, r, lat);
    check("t3_ovf_err", 32'(e), 32'd1);
    tick();
    check("t3_ovf_nopush", 32'(n_push - p0), 32'd0);
    check("t3_ovf_count", 32'(count), 32'd1024);
    cpu_do(1'b1, 32'd0, e, r, lat);
    check("t3_top", r, 32'd1023);
    for (int i = 0; i < 3; i++) cpu_do(1'b1, 32'd0, e, r, lat);

    // 4: ISR length/overflow rejection at count 1020
    check("t4_count1020", 32'(count), 32'd1020);
    p0 = n_push;
    isr_do(1'b0, 5'd5, 32'hB0, e);
    check("t4_len5_err", 32'(e), 32'd1);
    tick();
    check("t4_len5_nopush", 32'(n_push - p0), 32'd0);
    check("t4_len5_count", 32'(count), 32'd1020);
    isr_do(1'b0, 5'd0, 32'hB0, e);
    check("t4_len0_err", 32'(e), 32'd1);
    isr_do(1'b1, 5'd17, 32'hB0, e);
    check("t4_len17_err", 32'(e), 32'd1);
    isr_do(1'b0, 5'd4, 32'hC0, e);
    tick();
    check("t4_exact_fit_err", 32'(e), 32'd0);
    check("t4_exact_fit_full", 32'(full), 32'd1);
    for (int i = 0; i < 64; i++) begin
      isr_do(1'b1, 5'd16, 32'd0, e);
      if (i == 0 && rdq.size() > 0) check("t4_drain_first", rdq[0], 32'hC3);
    end
    if (rdq.size() == 16) check("t4_drain_last", rdq[15], 32'd0);
    tick();
    check("t4_drained", 32'(count), 32'd0);
    p0 = n_pop;
    cpu_do(1'b1, 32'd0, e, r, lat);
    check("t3_udf_err", 32'(e), 32'd1);
    tick();
    check("t3_udf_nopop", 32'(n_pop - p0), 32'd0);
    check("t3_udf_empty", 32'(empty), 32'd1);

    // 5: simultaneous requests alternate ISR, CPU, ISR
    order = '0; n_gnt = 0; done_cyc = -1; cgnt_cyc = -1; reraised = 1'b0;
    cpu_op = 1'b0; cpu_wdata = 32'h11; cpu_req = 1'b1;
    isr_op = 1'b0; isr_len = 5'd2; isr_wdata = 32'h22; isr_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (isr_gnt) begin
        order = {order[1:0], 1'b1}; n_gnt++; isr_req = 1'b0;
      end
      if (cpu_gnt) begin
        order = {order[1:0], 1'b0}; n_gnt++; cpu_req = 1'b0; cgnt_cyc = c;
      end
      if (isr_done && !reraised) begin
        done_cyc = c; reraised = 1'b1; isr_req = 1'b1;
      end
    end
    isr_req = 1'b0; cpu_req = 1'b0;
    check("t5_ngrants", 32'(n_gnt), 32'd3);
    check("t5_order", 32'(order), 32'b101);
    check("t5_cpu_after_done", 32'(cgnt_cyc > done_cyc && done_cyc >= 0), 32'd1);
    check("t5_count", 32'(count), 32'd5);
    check("no_push_pop_overlap", 32'(n_overlap), 32'd0);

    // 6: async reset in the middle of a push burst
    isr_op = 1'b0; isr_len = 5'd8; isr_wdata = 32'h77; isr_req = 1'b1;
    begin
      logic g;
      g = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (isr_gnt) begin
          g = 1'b1;
          break;
        end
      end
      check("t6_gnt", 32'(g), 32'd1);
    end
    isr_req = 1'b0;
    tick();
    check("t6_midburst", 32'(isr_wr_rdy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_push", 32'(stk_push), 32'd0);
    check("t6_rst_wrrdy", 32'(isr_wr_rdy), 32'd0);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    #10 rst_n = 1'b1;
    cpu_do(1'b1, 32'd0, e, r, lat);
    check("t6_pop_err", 32'(e), 32'd1);
    check("t6_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
